// File: rtl/matmul_chk_pkg.sv
// matmul_chk_pkg: shared state encoding, memory-map bases and LED bit positions
// for the on-chip matrix-multiply result checker.  Rev 1.0
`default_nettype none

package matmul_chk_pkg;

  localparam int STATE_W = 3;
  localparam int IDX_W   = 16;
  localparam int CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_MAC  = 3'd3,
    ST_RD_R = 3'd4,
    ST_CMP  = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  // Word-address bases of the three row-major regions in data memory
  function automatic int a_base();
    return 0;
  endfunction

  function automatic int b_base(input int m, input int n);
    return m * n;
  endfunction

  function automatic int r_base(input int m, input int n, input int n2);
    return m * n + n * n2;
  endfunction

  localparam int LED_DONE    = 0;
  localparam int LED_PASS    = 1;
  localparam int LED_BUSY    = 2;
  localparam int LED_CNT_LSB = 3;
  localparam int LED_CNT_MSB = 9;

endpackage

`default_nettype wire

// File: rtl/signed_mac.sv
// signed_mac: DW-bit signed multiply-accumulate, synchronous clear, wraps modulo 2^DW.
// Rev 1.0
`default_nettype none

module signed_mac #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  // Low DW bits of the product are identical for signed and unsigned operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + a * b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/matmul_result_checker.sv
// matmul_result_checker: re-reads A, B and R from data memory, recomputes each
// product element and reports pass/fail, mismatch count and first bad index. Rev 1.0
`default_nettype none

module matmul_result_checker
  import matmul_chk_pkg::*;
#(
  parameter int M  = 100,
  parameter int N  = 50,
  parameter int N2 = 2,
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  input  logic          start,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   mismatch_cnt,
  output logic [15:0]   bad_row,
  output logic [15:0]   bad_col,
  output logic [9:0]    LEDR
);

  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(M - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N2 - 1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);
  localparam logic [AW-1:0]    A_BASE = AW'(a_base());
  localparam logic [AW-1:0]    B_BASE = AW'(b_base(M, N));
  localparam logic [AW-1:0]    R_BASE = AW'(r_base(M, N, N2));

  state_t           state, state_nxt;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    acc;
  logic [IDX_W-1:0] i_q, j_q, k_q;

  logic accept, last_k, last_elem, mac_clr, mac_en;

  assign accept    = (state == ST_IDLE) && start;
  assign last_k    = (k_q == K_LAST);
  assign last_elem = (i_q == I_LAST) && (j_q == J_LAST);
  assign mac_clr   = accept || (state == ST_CMP);
  assign mac_en    = (state == ST_MAC);

  signed_mac #(.DW(DW)) u_mac (
    .clk   (CLOCK_50),
    .rst_n (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_q),
    .b     (mem_rdata),
    .acc   (acc)
  );

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read strobe and address are decoded from the state so memory sees them in the same cycle
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RD_A;
      ST_RD_A: begin
        mem_rd_en = 1'b1;
        mem_addr  = A_BASE + AW'(i_q) * AW'(N) + AW'(k_q);
        state_nxt = ST_RD_B;
      end
      ST_RD_B: begin
        mem_rd_en = 1'b1;
        mem_addr  = B_BASE + AW'(k_q) * AW'(N2) + AW'(j_q);
        state_nxt = ST_MAC;
      end
      ST_MAC:  state_nxt = last_k ? ST_RD_R : ST_RD_A;
      ST_RD_R: begin
        mem_rd_en = 1'b1;
        mem_addr  = R_BASE + AW'(i_q) * AW'(N2) + AW'(j_q);
        state_nxt = ST_CMP;
      end
      ST_CMP:  state_nxt = last_elem ? ST_FIN : ST_RD_A;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      a_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      bad_row      <= '0;
      bad_col      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            mismatch_cnt <= '0;
            bad_row      <= '0;
            bad_col      <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b1;
          end
        end
        ST_RD_B: a_q <= mem_rdata;
        ST_MAC:  if (!last_k) k_q <= k_q + 1'b1;
        ST_CMP: begin
          if (mem_rdata != acc) begin
            if (mismatch_cnt == '0) begin
              bad_row <= i_q;
              bad_col <= j_q;
            end
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
          end
          k_q <= '0;
          if (!last_elem) begin
            if (j_q == J_LAST) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        ST_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (mismatch_cnt == '0);
        end
        default: ;
      endcase
    end
  end

  assign LEDR[LED_DONE] = done;
  assign LEDR[LED_PASS] = pass;
  assign LEDR[LED_BUSY] = busy;
  assign LEDR[LED_CNT_MSB:LED_CNT_LSB] = (mismatch_cnt > 16'd127) ? 7'h7F : mismatch_cnt[6:0];

endmodule

`default_nettype wire

// File: tb/tb_matmul_result_checker.sv
// tb_matmul_result_checker: three checker instances (2x2x2, 1x1x1, 100x50x2) against
// word-array memories and a loop-level reference model. Rev 1.0
`default_nettype none

module tb_matmul_result_checker;

  localparam int MEMW   = 5300;
  localparam int DM [3] = '{2, 1, 100};
  localparam int DN [3] = '{2, 1, 50};
  localparam int DN2[3] = '{2, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  wire  [2:0]  rd_en_v, busy_v, done_v, pass_v;
  wire  [15:0] addr_v [3];
  wire  [15:0] cnt_v  [3];
  wire  [15:0] brow_v [3];
  wire  [15:0] bcol_v [3];
  wire  [9:0]  led_v  [3];
  logic [31:0] rdata_r [3];
  logic [31:0] mem [3][0:MEMW-1];

  int checks = 0;
  int errors = 0;
  int reads    [3] = '{0, 0, 0};
  int addr_err [3] = '{0, 0, 0};
  int base_rd  [3] = '{0, 0, 0};
  int base_err [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  matmul_result_checker #(.M(2), .N(2), .N2(2), .DW(32), .AW(16)) u_small (
    .CLOCK_50(clk), .rst(rst_n), .start(start_v[0]), .mem_rd_en(rd_en_v[0]),
    .mem_addr(addr_v[0]), .mem_rdata(rdata_r[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .mismatch_cnt(cnt_v[0]), .bad_row(brow_v[0]), .bad_col(bcol_v[0]),
    .LEDR(led_v[0]));

  matmul_result_checker #(.M(1), .N(1), .N2(1), .DW(32), .AW(16)) u_tiny (
    .CLOCK_50(clk), .rst(rst_n), .start(start_v[1]), .mem_rd_en(rd_en_v[1]),
    .mem_addr(addr_v[1]), .mem_rdata(rdata_r[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .mismatch_cnt(cnt_v[1]), .bad_row(brow_v[1]), .bad_col(bcol_v[1]),
    .LEDR(led_v[1]));

  matmul_result_checker #(.M(100), .N(50), .N2(2), .DW(32), .AW(16)) u_big (
    .CLOCK_50(clk), .rst(rst_n), .start(start_v[2]), .mem_rd_en(rd_en_v[2]),
    .mem_addr(addr_v[2]), .mem_rdata(rdata_r[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .mismatch_cnt(cnt_v[2]), .bad_row(brow_v[2]), .bad_col(bcol_v[2]),
    .LEDR(led_v[2]));

  // Expected r-th read address of a run: each element reads (A,B) N times, then R
  function automatic int exp_addr(input int d, input int r);
    int n = DN[d];
    int n2 = DN2[d];
    int m = DM[d];
    int e = r / (2 * n + 1);
    int w = r % (2 * n + 1);
    int i = e / n2;
    int j = e % n2;
    if (w == 2 * n) return m * n + n * n2 + i * n2 + j;
    if (w % 2 == 0) return i * n + w / 2;
    return m * n + (w / 2) * n2 + j;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rd_en_v[d]) rdata_r[d] <= mem[d][addr_v[d]];
      if (rst_n && rd_en_v[d] === 1'b1) begin
        if (int'(addr_v[d]) != exp_addr(d, reads[d] - base_rd[d])) addr_err[d]++;
        reads[d]++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int prod(input int d, input int i, input int j);
    int sum = 0;
    for (int k = 0; k < DN[d]; k++)
      sum += int'(mem[d][i * DN[d] + k]) * int'(mem[d][DM[d] * DN[d] + k * DN2[d] + j]);
    return sum;
  endfunction

  task automatic fill_r(input int d);
    int rb = DM[d] * DN[d] + DN[d] * DN2[d];
    for (int i = 0; i < DM[d]; i++)
      for (int j = 0; j < DN2[d]; j++) mem[d][rb + i * DN2[d] + j] = prod(d, i, j);
  endtask

  task automatic fill_ab(input int d, input bit small_vals);
    for (int a = 0; a < DM[d] * DN[d] + DN[d] * DN2[d]; a++)
      mem[d][a] = small_vals ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
  endtask

  task automatic ref_model(input int d, output int cnt, output int br, output int bc);
    int rb = DM[d] * DN[d] + DN[d] * DN2[d];
    cnt = 0; br = 0; bc = 0;
    for (int i = 0; i < DM[d]; i++)
      for (int j = 0; j < DN2[d]; j++)
        if (mem[d][rb + i * DN2[d] + j] != 32'(prod(d, i, j))) begin
          if (cnt == 0) begin br = i; bc = j; end
          if (cnt < 65535) cnt++;
        end
  endtask

  task automatic run(input int d, input bit extra, input bit fin_start, output int lat);
    int exp_lat = DM[d] * DN2[d] * (3 * DN[d] + 2) + 2;
    base_rd[d]  = reads[d];
    base_err[d] = addr_err[d];
    start_v[d]  = 1'b1;
    lat = 0;
    while (lat < exp_lat + 20) begin
      @(posedge clk); #1;
      lat++;
      start_v[d] = 1'b0;
      if (lat == 1) check("busy_set", {31'd0, busy_v[d]}, 32'd1);
      if (done_v[d]) break;
      if (extra && lat % 997 == 0 && lat < exp_lat - 2) start_v[d] = 1'b1;
      if (fin_start && lat == exp_lat - 1) start_v[d] = 1'b1;
    end
    start_v[d] = 1'b0;
    check("latency", lat, exp_lat);
  endtask

  task automatic verify(input int d, input string tag);
    int cnt, br, bc;
    logic [9:0] led;
    ref_model(d, cnt, br, bc);
    led[0] = 1'b1;
    led[1] = (cnt == 0);
    led[2] = 1'b0;
    led[9:3] = (cnt > 127) ? 7'd127 : cnt[6:0];
    check({tag, "_done"}, {31'd0, done_v[d]}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_v[d]}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass_v[d]}, {31'd0, cnt == 0});
    check({tag, "_cnt"}, {16'd0, cnt_v[d]}, cnt);
    check({tag, "_brow"}, {16'd0, brow_v[d]}, br);
    check({tag, "_bcol"}, {16'd0, bcol_v[d]}, bc);
    check({tag, "_ledr"}, {22'd0, led_v[d]}, {22'd0, led});
    check({tag, "_rd_count"}, reads[d] - base_rd[d], DM[d] * DN2[d] * (2 * DN[d] + 1));
    check({tag, "_addr_seq"}, addr_err[d] - base_err[d], 0);
  endtask

  task automatic set_small(input int a[4], input int b[4], input int r[4]);
    for (int x = 0; x < 4; x++) begin
      mem[0][x] = a[x];
      mem[0][4 + x] = b[x];
      mem[0][8 + x] = r[x];
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_busy"}, {31'd0, busy_v[d]}, 32'd0);
    check({tag, "_done"}, {31'd0, done_v[d]}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass_v[d]}, 32'd0);
    check({tag, "_cnt"}, {16'd0, cnt_v[d]}, 32'd0);
    check({tag, "_bad"}, {brow_v[d], bcol_v[d]}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, rd_en_v[d]}, 32'd0);
    check({tag, "_addr"}, {16'd0, addr_v[d]}, 32'd0);
    check({tag, "_ledr"}, {22'd0, led_v[d]}, 32'd0);
  endtask

  initial begin
    int lat;
    int rb;
    rst_n = 1'b0;
    start_v = 3'b000;
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < MEMW; a++) mem[d][a] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed pass case, with a start landing on the FIN cycle
    set_small('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 43, 50});
    run(0, 1'b0, 1'b1, lat);
    verify(0, "pass2x2");
    repeat (3) @(posedge clk);
    #1;
    check("fin_start_done_hold", {31'd0, done_v[0]}, 32'd1);
    check("fin_start_ignored", {31'd0, busy_v[0]}, 32'd0);

    set_small('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{19, 22, 44, 50});
    run(0, 1'b0, 1'b0, lat);
    verify(0, "single_err");

    mem[1][0] = -32'sd3; mem[1][1] = 32'd7; mem[1][2] = -32'sd21;
    run(1, 1'b0, 1'b0, lat);
    verify(1, "tiny_signed");
    mem[1][0] = 32'h7FFFFFFF; mem[1][1] = 32'd2; mem[1][2] = 32'hFFFFFFFE;
    run(1, 1'b0, 1'b0, lat);
    verify(1, "tiny_wrap");
    mem[1][2] = 32'h0;
    run(1, 1'b0, 1'b0, lat);
    verify(1, "tiny_wrap_bad");

    for (int t = 0; t < 4; t++) begin
      fill_ab(0, t[0]);
      fill_r(0);
      for (int e = 0; e < 4; e++)
        if ($urandom_range(0, 2) == 0) mem[0][8 + e] ^= 32'h1 << $urandom_range(0, 31);
      run(0, 1'b0, 1'b0, lat);
      verify(0, "rand_small");
    end

    // Reset during the MAC of element (0,1), then a clean rerun
    fill_ab(0, 1'b1);
    fill_r(0);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrun_busy", {31'd0, busy_v[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0, "midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 1'b0, 1'b0, lat);
    verify(0, "after_reset");

    for (int e = 0; e < 4; e++) mem[0][8 + e] = mem[0][8 + e] + 32'd1;
    run(0, 1'b0, 1'b0, lat);
    verify(0, "all_wrong");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero(0, "idle_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-size run with random data, three corrupted results and stray start pulses
    fill_ab(2, 1'b0);
    fill_r(2);
    rb = 100 * 50 + 50 * 2;
    mem[2][rb + $urandom_range(0, 60)]   ^= 32'h0000_0100;
    mem[2][rb + $urandom_range(61, 130)] ^= 32'h8000_0000;
    mem[2][rb + $urandom_range(131, 199)] ^= 32'h0000_0001;
    run(2, 1'b1, 1'b0, lat);
    verify(2, "big");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
